// File: rtl/fg_prog_sequencer_pkg.sv
// Shared encodings for the floating-gate programming sequencer.
package fg_prog_sequencer_pkg;

  localparam int unsigned DEFAULT_SETTLE = 8;

  typedef enum logic [1:0] {
    OP_INJECT = 2'b00,
    OP_TUNNEL = 2'b01,
    OP_RUN    = 2'b10,
    OP_RSVD   = 2'b11
  } fg_op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_PULSE   = 3'd2,
    ST_GAP     = 3'd3,
    ST_RELEASE = 3'd4
  } fg_state_e;

endpackage

// File: rtl/fg_prog_sequencer_timer.sv
// Down-counter used for switch-settle and pulse-width timing; saturates at zero.
module fg_pulse_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             last_c,
  output logic             zero_c
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  // last_c marks the final cycle of a loaded interval
  assign last_c = (count == CNT_W'(1));
  assign zero_c = (count == '0);

endmodule

// File: rtl/fg_prog_sequencer.sv
// Sequences drain/gate switch setup, inject/tunnel pulse trains and release for one FG cell.
module fg_prog_sequencer
  import fg_prog_sequencer_pkg::*;
#(
  parameter int unsigned ROW_BITS = 2,
  parameter int unsigned COL_BITS = 3,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned SETTLE   = DEFAULT_SETTLE
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [ROW_BITS-1:0] cmd_row,
  input  logic [COL_BITS-1:0] cmd_col,
  input  logic [7:0]          cmd_pulses,
  input  logic [CNT_W-1:0]    cmd_width,
  input  logic                abort,
  output logic                prog_mode,
  output logic [ROW_BITS-1:0] drain_addr,
  output logic                drain_en,
  output logic [COL_BITS-1:0] gate_addr,
  output logic                gate_en,
  output logic                vinj_pulse,
  output logic                vtun_en,
  output logic                busy,
  output logic                done,
  output logic                err
);

  fg_state_e           state_q, state_d;
  fg_op_e              op_q, op_d, new_op;
  logic [CNT_W-1:0]    width_q, width_d;
  logic [7:0]          pulse_left_q, pulse_left_d;
  logic                aborted_q, aborted_d;
  logic                prog_mode_d, drain_en_d, gate_en_d, vinj_d, vtun_d, done_d, err_d;
  logic [ROW_BITS-1:0] drain_addr_d;
  logic [COL_BITS-1:0] gate_addr_d;
  logic                tmr_load, tmr_last, tmr_zero;
  logic [CNT_W-1:0]    tmr_val;
  logic                reject, go_release, rel_aborted;

  fg_pulse_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .last_c   (tmr_last),
    .zero_c   (tmr_zero)
  );

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_INJECT;
      width_q      <= '0;
      pulse_left_q <= '0;
      aborted_q    <= 1'b0;
      prog_mode    <= 1'b0;
      drain_addr   <= '0;
      drain_en     <= 1'b0;
      gate_addr    <= '0;
      gate_en      <= 1'b0;
      vinj_pulse   <= 1'b0;
      vtun_en      <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      busy         <= 1'b0;
      cmd_ready    <= 1'b1;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      width_q      <= width_d;
      pulse_left_q <= pulse_left_d;
      aborted_q    <= aborted_d;
      prog_mode    <= prog_mode_d;
      drain_addr   <= drain_addr_d;
      drain_en     <= drain_en_d;
      gate_addr    <= gate_addr_d;
      gate_en      <= gate_en_d;
      vinj_pulse   <= vinj_d;
      vtun_en      <= vtun_d;
      done         <= done_d;
      err          <= err_d;
      busy         <= (state_d != ST_IDLE);
      cmd_ready    <= (state_d == ST_IDLE);
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    width_d      = width_q;
    pulse_left_d = pulse_left_q;
    aborted_d    = aborted_q;
    prog_mode_d  = prog_mode;
    drain_addr_d = drain_addr;
    drain_en_d   = drain_en;
    gate_addr_d  = gate_addr;
    gate_en_d    = gate_en;
    vinj_d       = vinj_pulse;
    vtun_d       = vtun_en;
    done_d       = 1'b0;
    err_d        = 1'b0;
    tmr_load     = 1'b0;
    tmr_val      = '0;
    go_release   = 1'b0;
    rel_aborted  = 1'b0;
    new_op       = fg_op_e'(cmd_op);
    reject       = (new_op == OP_RSVD) ||
                   ((new_op != OP_RUN) && ((cmd_width == '0) || (cmd_pulses == 8'd0)));

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_d         = new_op;
          width_d      = cmd_width;
          pulse_left_d = cmd_pulses;
          aborted_d    = 1'b0;
          // Reject and RUN finish through a zero-length release: one busy cycle carrying done
          if (reject) begin
            state_d  = ST_RELEASE;
            tmr_load = 1'b1;
            done_d   = 1'b1;
            err_d    = 1'b1;
          end else if (new_op == OP_RUN) begin
            state_d     = ST_RELEASE;
            tmr_load    = 1'b1;
            prog_mode_d = 1'b0;
            drain_en_d  = 1'b0;
            gate_en_d   = 1'b0;
            done_d      = 1'b1;
          end else begin
            state_d     = ST_SETUP;
            tmr_load    = 1'b1;
            tmr_val     = CNT_W'(SETTLE);
            prog_mode_d = 1'b1;
            if (new_op == OP_INJECT) begin
              drain_addr_d = cmd_row;
              gate_addr_d  = cmd_col;
              drain_en_d   = 1'b1;
              gate_en_d    = 1'b1;
            end else begin
              drain_en_d = 1'b0;
              gate_en_d  = 1'b0;
            end
          end
        end
      end
      ST_SETUP: begin
        if (abort) begin
          go_release  = 1'b1;
          rel_aborted = 1'b1;
        end else if (tmr_last) begin
          state_d  = ST_PULSE;
          tmr_load = 1'b1;
          tmr_val  = width_q;
          vinj_d   = (op_q == OP_INJECT);
          vtun_d   = (op_q == OP_TUNNEL);
        end
      end
      ST_PULSE: begin
        if (abort) begin
          go_release  = 1'b1;
          rel_aborted = 1'b1;
        end else if (tmr_last) begin
          state_d      = ST_GAP;
          tmr_load     = 1'b1;
          tmr_val      = width_q;
          vinj_d       = 1'b0;
          vtun_d       = 1'b0;
          pulse_left_d = pulse_left_q - 8'd1;
        end
      end
      ST_GAP: begin
        if (abort) begin
          go_release  = 1'b1;
          rel_aborted = 1'b1;
        end else if (tmr_last) begin
          if (pulse_left_q != 8'd0) begin
            state_d  = ST_PULSE;
            tmr_load = 1'b1;
            tmr_val  = width_q;
            vinj_d   = (op_q == OP_INJECT);
            vtun_d   = (op_q == OP_TUNNEL);
          end else begin
            go_release = 1'b1;
          end
        end
      end
      ST_RELEASE: begin
        if (tmr_zero) begin
          state_d = ST_IDLE;
        end else if (tmr_last) begin
          done_d = 1'b1;
          err_d  = aborted_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Release drops all switches and pulses, keeps prog_mode for the settle interval
    if (go_release) begin
      state_d    = ST_RELEASE;
      tmr_load   = 1'b1;
      tmr_val    = CNT_W'(SETTLE);
      drain_en_d = 1'b0;
      gate_en_d  = 1'b0;
      vinj_d     = 1'b0;
      vtun_d     = 1'b0;
      aborted_d  = rel_aborted;
    end
  end

endmodule

// File: tb/tb_fg_prog_sequencer.sv
// Directed bench for fg_prog_sequencer: per-cycle traces plus a table of command outcomes.
module tb_fg_prog_sequencer;

  localparam int unsigned RB = 2;
  localparam int unsigned CB = 3;
  localparam int unsigned CW = 8;
  localparam int unsigned ST = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_op;
  logic [RB-1:0] cmd_row;
  logic [CB-1:0] cmd_col;
  logic [7:0]    cmd_pulses;
  logic [CW-1:0] cmd_width;
  logic          abort;
  logic          prog_mode, drain_en, gate_en, vinj_pulse, vtun_en, busy, done, err;
  logic [RB-1:0] drain_addr;
  logic [CB-1:0] gate_addr;

  int checks = 0;
  int errors = 0;

  fg_prog_sequencer #(.ROW_BITS(RB), .COL_BITS(CB), .CNT_W(CW), .SETTLE(ST)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_row    (cmd_row),
    .cmd_col    (cmd_col),
    .cmd_pulses (cmd_pulses),
    .cmd_width  (cmd_width),
    .abort      (abort),
    .prog_mode  (prog_mode),
    .drain_addr (drain_addr),
    .drain_en   (drain_en),
    .gate_addr  (gate_addr),
    .gate_en    (gate_en),
    .vinj_pulse (vinj_pulse),
    .vtun_en    (vtun_en),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout exp finish");
    $fatal(1);
  end

  // Observed vector: {pm, de, ge, vinj, vtun, busy, done, err, ready, drain_addr, gate_addr}
  function automatic logic [13:0] ev(logic pm, logic de, logic ge, logic vi, logic vt,
                                     logic bz, logic dn, logic er, logic rd,
                                     logic [1:0] da, logic [2:0] ga);
    return {pm, de, ge, vi, vt, bz, dn, er, rd, da, ga};
  endfunction

  function automatic logic [13:0] obs();
    return {prog_mode, drain_en, gate_en, vinj_pulse, vtun_en, busy, done, err, cmd_ready,
            drain_addr, gate_addr};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input string name, input logic [13:0] e);
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL %s: got %b exp %b", name, obs(), e);
    end
  endtask

  task automatic chk_int(input string name, input int idx, input int got, input int e);
    checks++;
    if (got != e) begin
      errors++;
      $display("FAIL %s[%0d]: got %0d exp %0d", name, idx, got, e);
    end
  endtask

  task automatic expect_cycles(input string name, input int n, input logic [13:0] e);
    for (int i = 0; i < n; i++) begin
      check_vec(name, e);
      step();
    end
  endtask

  // Present one command; returns #1 after the accepting edge with cmd_* scrambled
  task automatic issue(input logic [1:0] op, input logic [1:0] row, input logic [2:0] col,
                       input logic [7:0] p, input logic [7:0] w);
    int n;
    n = 0;
    while (!cmd_ready && n < 50) begin
      step();
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_ready: got 0 exp 1 within 50 cycles");
    end
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_row    = row;
    cmd_col    = col;
    cmd_pulses = p;
    cmd_width  = w;
    step();
    cmd_valid  = 1'b0;
    cmd_op     = 2'($urandom);
    cmd_row    = 2'($urandom);
    cmd_col    = 3'($urandom);
    cmd_pulses = 8'($urandom);
    cmd_width  = 8'($urandom);
  endtask

  typedef struct {
    logic [1:0] op;
    logic [1:0] row;
    logic [2:0] col;
    logic [7:0] pulses;
    logic [7:0] width;
    int         lat;
    logic       err;
    int         inj;
    int         tun;
    int         np;
    int         en;
    logic       pm;
    logic [1:0] da;
    logic [2:0] ga;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int lat, inj, tun, np, en, ovl;
    logic got_err, got_pm, prev;
    logic [1:0] got_da;
    logic [2:0] got_ga;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_row = '0; cmd_col = '0;
    cmd_pulses = '0; cmd_width = '0; abort = 1'b0;

    //          op     row col pulses width lat err inj tun np  en  pm da ga
    tbl[0] = '{2'b00, 2'd1, 3'd6, 8'd2, 8'd3,  29, 1'b0, 6,  0, 2, 20, 1'b1, 2'd1, 3'd6};
    tbl[1] = '{2'b01, 2'd3, 3'd2, 8'd1, 8'd10, 37, 1'b0, 0, 10, 1,  0, 1'b1, 2'd1, 3'd6};
    tbl[2] = '{2'b00, 2'd2, 3'd2, 8'd2, 8'd0,   1, 1'b1, 0,  0, 0,  0, 1'b1, 2'd1, 3'd6};
    tbl[3] = '{2'b10, 2'd0, 3'd1, 8'd0, 8'd0,   1, 1'b0, 0,  0, 0,  0, 1'b0, 2'd1, 3'd6};
    tbl[4] = '{2'b01, 2'd0, 3'd0, 8'd0, 8'd3,   1, 1'b1, 0,  0, 0,  0, 1'b0, 2'd1, 3'd6};
    tbl[5] = '{2'b11, 2'd2, 3'd3, 8'd1, 8'd1,   1, 1'b1, 0,  0, 0,  0, 1'b0, 2'd1, 3'd6};
    tbl[6] = '{2'b00, 2'd3, 3'd7, 8'd2, 8'd1,  21, 1'b0, 2,  0, 2, 12, 1'b1, 2'd3, 3'd7};
    tbl[7] = '{2'b10, 2'd1, 3'd1, 8'd4, 8'd4,   1, 1'b0, 0,  0, 0,  0, 1'b0, 2'd3, 3'd7};
    tbl[8] = '{2'b00, 2'd0, 3'd0, 8'd1, 8'd255, 527, 1'b0, 255, 0, 1, 518, 1'b1, 2'd0, 3'd0};
    tbl[9] = '{2'b01, 2'd2, 3'd5, 8'd3, 8'd2,  29, 1'b0, 0,  6, 3,  0, 1'b1, 2'd0, 3'd0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_vec("reset_hold", ev(0,0,0,0,0,0,0,0,1,2'd0,3'd0));
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_vec("reset_idle", ev(0,0,0,0,0,0,0,0,1,2'd0,3'd0));

    // INJECT row 2 col 5, 3 pulses of 4: exact timeline
    issue(2'b00, 2'd2, 3'd5, 8'd3, 8'd4);
    expect_cycles("inj_setup", ST, ev(1,1,1,0,0,1,0,0,0,2'd2,3'd5));
    for (int p = 0; p < 3; p++) begin
      expect_cycles("inj_pulse", 4, ev(1,1,1,1,0,1,0,0,0,2'd2,3'd5));
      expect_cycles("inj_gap", 4, ev(1,1,1,0,0,1,0,0,0,2'd2,3'd5));
    end
    expect_cycles("inj_release", ST, ev(1,0,0,0,0,1,0,0,0,2'd2,3'd5));
    expect_cycles("inj_done", 1, ev(1,0,0,0,0,1,1,0,0,2'd2,3'd5));
    check_vec("inj_idle", ev(1,0,0,0,0,0,0,0,1,2'd2,3'd5));

    // Table of commands: summarise each run up to done
    for (int i = 0; i < 10; i++) begin
      issue(tbl[i].op, tbl[i].row, tbl[i].col, tbl[i].pulses, tbl[i].width);
      lat = 0; inj = 0; tun = 0; np = 0; en = 0; ovl = 0; prev = 1'b0;
      got_err = 1'b0; got_pm = 1'b0; got_da = '0; got_ga = '0;
      for (int k = 1; k <= 1000; k++) begin
        if (vinj_pulse) inj++;
        if (vtun_en) tun++;
        if (vinj_pulse && vtun_en) ovl++;
        if ((vinj_pulse || vtun_en) && !prev) np++;
        prev = vinj_pulse || vtun_en;
        if (drain_en) en++;
        if (done) begin
          lat = k; got_err = err; got_pm = prog_mode; got_da = drain_addr; got_ga = gate_addr;
          step();
          break;
        end
        step();
      end
      chk_int("tbl_latency", i, lat, tbl[i].lat);
      chk_int("tbl_err", i, int'(got_err), int'(tbl[i].err));
      chk_int("tbl_vinj_cycles", i, inj, tbl[i].inj);
      chk_int("tbl_vtun_cycles", i, tun, tbl[i].tun);
      chk_int("tbl_pulse_count", i, np, tbl[i].np);
      chk_int("tbl_enable_cycles", i, en, tbl[i].en);
      chk_int("tbl_overlap", i, ovl, 0);
      chk_int("tbl_prog_mode", i, int'(got_pm), int'(tbl[i].pm));
      chk_int("tbl_addr", i, int'({got_da, got_ga}), int'({tbl[i].da, tbl[i].ga}));
      chk_int("tbl_idle_after", i, int'({cmd_ready, busy, done}), 4);
    end

    // Abort in the 2nd of 5 pulses; abort during release has no effect
    issue(2'b00, 2'd1, 3'd2, 8'd5, 8'd3);
    expect_cycles("ab_setup", ST, ev(1,1,1,0,0,1,0,0,0,2'd1,3'd2));
    expect_cycles("ab_pulse1", 3, ev(1,1,1,1,0,1,0,0,0,2'd1,3'd2));
    expect_cycles("ab_gap1", 3, ev(1,1,1,0,0,1,0,0,0,2'd1,3'd2));
    expect_cycles("ab_pulse2", 1, ev(1,1,1,1,0,1,0,0,0,2'd1,3'd2));
    abort = 1'b1;
    check_vec("ab_pulse2_hold", ev(1,1,1,1,0,1,0,0,0,2'd1,3'd2));
    step();
    abort = 1'b0;
    expect_cycles("ab_release", 2, ev(1,0,0,0,0,1,0,0,0,2'd1,3'd2));
    abort = 1'b1;
    expect_cycles("ab_release_abort", 1, ev(1,0,0,0,0,1,0,0,0,2'd1,3'd2));
    abort = 1'b0;
    expect_cycles("ab_release_tail", ST - 3, ev(1,0,0,0,0,1,0,0,0,2'd1,3'd2));
    expect_cycles("ab_done_err", 1, ev(1,0,0,0,0,1,1,1,0,2'd1,3'd2));
    check_vec("ab_idle", ev(1,0,0,0,0,0,0,0,1,2'd1,3'd2));

    // RUN offered during the done cycle is taken the cycle after
    issue(2'b00, 2'd0, 3'd3, 8'd1, 8'd1);
    for (int k = 0; k < 100 && !done; k++) step();
    check_vec("b2b_done", ev(1,0,0,0,0,1,1,0,0,2'd0,3'd3));
    cmd_valid = 1'b1; cmd_op = 2'b10;
    step();
    check_vec("b2b_ready", ev(1,0,0,0,0,0,0,0,1,2'd0,3'd3));
    step();
    cmd_valid = 1'b0;
    check_vec("b2b_run_done", ev(0,0,0,0,0,1,1,0,0,2'd0,3'd3));
    step();
    check_vec("b2b_idle", ev(0,0,0,0,0,0,0,0,1,2'd0,3'd3));

    // Abort while idle is ignored
    abort = 1'b1;
    expect_cycles("idle_abort", 3, ev(0,0,0,0,0,0,0,0,1,2'd0,3'd3));
    abort = 1'b0;

    // Asynchronous reset mid-pulse
    issue(2'b00, 2'd3, 3'd4, 8'd2, 8'd5);
    repeat (ST + 1) step();
    check_vec("rst_pre_pulse", ev(1,1,1,1,0,1,0,0,0,2'd3,3'd4));
    #2;
    rst_n = 1'b0;
    #1;
    check_vec("rst_async", ev(0,0,0,0,0,0,0,0,1,2'd0,3'd0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_vec("rst_released", ev(0,0,0,0,0,0,0,0,1,2'd0,3'd0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
